// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage RISC-V core.
//   - Bit positions inside the 8-bit decode control word
//     {ALUOp[1:0], ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Branch}
//   - Common field widths
//   - Major opcode constants used by the decoder
package cpu_pkg;

  localparam int CTL_W      = 8;
  localparam int REG_ADDR_W = 5;
  localparam int FUNCT_W    = 10;  // {funct7, funct3}

  // Control-word bit indices
  localparam int CTL_BRANCH    = 0;
  localparam int CTL_MEMWRITE  = 1;
  localparam int CTL_MEMREAD   = 2;
  localparam int CTL_MEMTOREG  = 3;
  localparam int CTL_REGWRITE  = 4;
  localparam int CTL_ALUSRC    = 5;
  localparam int CTL_ALUOP_LSB = 6;
  localparam int CTL_ALUOP_MSB = 7;

  // RV32I major opcodes
  typedef enum logic [6:0] {
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
//   ex_mem_read  in  1           MemRead bit of the instruction now in EX
//   ex_rd        in  REG_ADDR_W  destination register of the instruction in EX
//   id_rs1       in  REG_ADDR_W  source register 1 of the instruction in ID
//   id_rs2       in  REG_ADDR_W  source register 2 of the instruction in ID
//   hazard       out 1           ID consumer needs a value the EX load has not fetched yet
// Both sources are compared regardless of opcode; an occasional extra stall
// on I-type instructions is cheaper than decoding which sources are real.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  hazard
);

  // x0 is hard-wired to zero, so a load targeting it can never be a producer.
  assign hazard = ex_mem_read
               && (ex_rd != '0)
               && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble injection.
//   clk_i                   in   rising-edge clock
//   rst_i                   in   asynchronous active-low reset (all outputs -> 0)
//   control_i / control_o   8    decode control word in / EX control word out
//   rs1_data_*, rs2_data_*  DATA_W register operands
//   imm_*                   DATA_W sign-extended immediate
//   funct_*                 10   {funct7, funct3}
//   rs1_addr_*, rs2_addr_*  5    source addresses (outputs feed forwarding)
//   rd_addr_*               5    destination address
//   stall_o                 out  combinational: hold PC and IF/ID this cycle
//   bubble_cnt_o            out  CNT_W saturating count of injected bubbles
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CTL_W-1:0]      control_i,
  input  logic [DATA_W-1:0]     rs1_data_i,
  input  logic [DATA_W-1:0]     rs2_data_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [FUNCT_W-1:0]    funct_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic [CTL_W-1:0]      control_o,
  output logic [DATA_W-1:0]     rs1_data_o,
  output logic [DATA_W-1:0]     rs2_data_o,
  output logic [DATA_W-1:0]     imm_o,
  output logic [FUNCT_W-1:0]    funct_o,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                  hazard;
  logic [CTL_W-1:0]      control_next;
  logic [REG_ADDR_W-1:0] rd_addr_next;

  // The detector looks at what is already in EX against what is in ID now,
  // so the stall is known in the same cycle the consumer sits in ID.
  load_use_detect u_load_use_detect (
    .ex_mem_read (control_o[CTL_MEMREAD]),
    .ex_rd       (rd_addr_o),
    .id_rs1      (rs1_addr_i),
    .id_rs2      (rs2_addr_i),
    .hazard      (hazard)
  );

  assign stall_o = hazard;

  // A bubble is a zeroed control word plus rd = 0. Only these two fields
  // matter; the operands are don't-care under a bubble and load as usual.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    control_next = control_i;
    rd_addr_next = rd_addr_i;
    if (hazard) begin
      control_next = '0;
      rd_addr_next = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      control_o  <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      funct_o    <= '0;
      rs1_addr_o <= '0;
      rs2_addr_o <= '0;
      rd_addr_o  <= '0;
    end else begin
      control_o  <= control_next;
      rs1_data_o <= rs1_data_i;
      rs2_data_o <= rs2_data_i;
      imm_o      <= imm_i;
      funct_o    <= funct_i;
      rs1_addr_o <= rs1_addr_i;
      rs2_addr_o <= rs2_addr_i;
      rd_addr_o  <= rd_addr_next;
    end
  end

  // Performance counter: sticks at all-ones instead of wrapping so a long
  // run never reports a misleadingly small number.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
    end else if (hazard && (bubble_cnt_o != CNT_MAX)) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [7:0] CTL_R   = 8'b10010000;
  localparam logic [7:0] CTL_LD  = 8'b00111100;
  localparam logic [7:0] CTL_SD  = 8'b00100010;
  localparam logic [7:0] CTL_ADI = 8'b10110000;
  localparam logic [7:0] CTL_MIX = 8'b11101011;  // MemRead clear

  logic              clk;
  logic              rst_i;
  logic [7:0]        control_i;
  logic [DATA_W-1:0] rs1_data_i, rs2_data_i, imm_i;
  logic [9:0]        funct_i;
  logic [4:0]        rs1_addr_i, rs2_addr_i, rd_addr_i;

  logic [7:0]        control_o;
  logic [DATA_W-1:0] rs1_data_o, rs2_data_o, imm_o;
  logic [9:0]        funct_o;
  logic [4:0]        rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic              stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  logic [7:0]        s_control_o;
  logic [DATA_W-1:0] s_rs1_data_o, s_rs2_data_o, s_imm_o;
  logic [9:0]        s_funct_o;
  logic [4:0]        s_rs1_addr_o, s_rs2_addr_o, s_rd_addr_o;
  logic              s_stall_o;
  logic [1:0]        s_bubble_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .control_i(control_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .funct_i(funct_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .control_o(control_o), .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o), .imm_o(imm_o), .funct_o(funct_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .control_i(control_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .funct_i(funct_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .control_o(s_control_o), .rs1_data_o(s_rs1_data_o),
    .rs2_data_o(s_rs2_data_o), .imm_o(s_imm_o), .funct_o(s_funct_o),
    .rs1_addr_o(s_rs1_addr_o), .rs2_addr_o(s_rs2_addr_o), .rd_addr_o(s_rd_addr_o),
    .stall_o(s_stall_o), .bubble_cnt_o(s_bubble_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] c, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d);
    control_i  = c;
    rs1_addr_i = a1;
    rs2_addr_i = a2;
    rd_addr_i  = d;
    #1;
  endtask

  task automatic test_reset();
    control_i  = CTL_MIX;  rs1_data_i = 32'hDEAD_BEEF; rs2_data_i = 32'hCAFE_F00D;
    imm_i      = 32'h0000_0FFF; funct_i = 10'h3FF;
    rs1_addr_i = 5'd11; rs2_addr_i = 5'd12; rd_addr_i = 5'd13;
    @(negedge clk);
    rst_i = 1'b1;
    tick();
    n_checks++;
    if (control_o !== CTL_MIX || rd_addr_o !== 5'd13 || rs1_data_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL reset_preload: ctl=%h rd=%0d rs1d=%h required ctl=%h rd=13 rs1d=deadbeef",
               control_o, rd_addr_o, rs1_data_o, CTL_MIX);
    end
    #3 rst_i = 1'b0;
    #1;
    n_checks++;
    if ({control_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o,
         rd_addr_o, bubble_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ctl=%h rs1d=%h rs2d=%h imm=%h funct=%h a1=%0d a2=%0d rd=%0d cnt=%0d required all 0",
               control_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o,
               rd_addr_o, bubble_cnt_o);
    end
    n_checks++;
    if (stall_o !== 1'b0 || s_bubble_cnt_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_stall: stall=%b sat_cnt=%0d required 0 0", stall_o, s_bubble_cnt_o);
    end
    // Release with a matching load in ID: EX holds a bubble so no stall.
    control_i = CTL_LD; rd_addr_i = 5'd13; rs1_addr_i = 5'd13;
    @(negedge clk);
    rst_i = 1'b1;
    tick();
    n_checks++;
    if (control_o !== CTL_LD || bubble_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_release_load: ctl=%h cnt=%0d required %h 0", control_o, bubble_cnt_o, CTL_LD);
    end
    drive(CTL_MIX, 5'd1, 5'd2, 5'd3);
    tick();
    exp_cnt = 0;
  endtask

  task automatic test_passthrough();
    rs1_data_i = 32'd5; rs2_data_i = 32'd7; imm_i = 32'h0000_1234; funct_i = 10'h020;
    drive(CTL_R, 5'd1, 5'd2, 5'd3);
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_stall_pre: stall=%b required 0", stall_o);
    end
    tick();
    n_checks++;
    if (control_o !== CTL_R || rs1_data_o !== 32'd5 || rs2_data_o !== 32'd7 || rd_addr_o !== 5'd3) begin
      n_fail++;
      $display("FAIL pass_main: ctl=%h rs1d=%0d rs2d=%0d rd=%0d required %h 5 7 3",
               control_o, rs1_data_o, rs2_data_o, rd_addr_o, CTL_R);
    end
    n_checks++;
    if (imm_o !== 32'h0000_1234 || funct_o !== 10'h020 || rs1_addr_o !== 5'd1 || rs2_addr_o !== 5'd2) begin
      n_fail++;
      $display("FAIL pass_aux: imm=%h funct=%h a1=%0d a2=%0d required 1234 020 1 2",
               imm_o, funct_o, rs1_addr_o, rs2_addr_o);
    end
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_stall_post: stall=%b required 0", stall_o);
    end
  endtask

  task automatic test_load_use();
    drive(CTL_LD, 5'd2, 5'd0, 5'd5);
    tick();
    drive(CTL_R, 5'd5, 5'd6, 5'd7);
    n_checks++;
    if (stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_stall: stall=%b required 1", stall_o);
    end
    tick();
    exp_cnt++;
    n_checks++;
    if (control_o !== 8'h00 || rd_addr_o !== 5'd0) begin
      n_fail++;
      $display("FAIL lu_bubble: ctl=%h rd=%0d required 00 0", control_o, rd_addr_o);
    end
    n_checks++;
    if (bubble_cnt_o !== 16'(exp_cnt) || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_cnt_stall_drop: cnt=%0d stall=%b required %0d 0", bubble_cnt_o, stall_o, exp_cnt);
    end
    tick();
    n_checks++;
    if (control_o !== CTL_R || rd_addr_o !== 5'd7 || rs1_addr_o !== 5'd5 || bubble_cnt_o !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL lu_consumer: ctl=%h rd=%0d a1=%0d cnt=%0d required %h 7 5 %0d",
               control_o, rd_addr_o, rs1_addr_o, bubble_cnt_o, CTL_R, exp_cnt);
    end
  endtask

  task automatic test_no_false_hazard();
    drive(CTL_LD, 5'd1, 5'd0, 5'd0);
    tick();
    drive(CTL_R, 5'd0, 5'd0, 5'd4);
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL nf_x0: stall=%b required 0", stall_o);
    end
    tick();
    drive(CTL_LD, 5'd1, 5'd1, 5'd5);
    tick();
    drive(CTL_R, 5'd6, 5'd7, 5'd8);
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL nf_other_regs: stall=%b required 0", stall_o);
    end
    tick();
    n_checks++;
    if (control_o !== CTL_R || rd_addr_o !== 5'd8 || bubble_cnt_o !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL nf_no_bubble: ctl=%h rd=%0d cnt=%0d required %h 8 %0d",
               control_o, rd_addr_o, bubble_cnt_o, CTL_R, exp_cnt);
    end
  endtask

  task automatic test_rs2_and_non_load();
    drive(CTL_LD, 5'd1, 5'd0, 5'd9);
    tick();
    drive(CTL_SD, 5'd1, 5'd9, 5'd0);
    n_checks++;
    if (stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rs2_stall: stall=%b required 1", stall_o);
    end
    tick();
    exp_cnt++;
    n_checks++;
    if (control_o !== 8'h00 || stall_o !== 1'b0 || bubble_cnt_o !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL rs2_bubble: ctl=%h stall=%b cnt=%0d required 00 0 %0d",
               control_o, stall_o, bubble_cnt_o, exp_cnt);
    end
    tick();
    n_checks++;
    if (control_o !== CTL_SD || rs2_addr_o !== 5'd9) begin
      n_fail++;
      $display("FAIL rs2_store_enters: ctl=%h a2=%0d required %h 9", control_o, rs2_addr_o, CTL_SD);
    end
    drive(CTL_ADI, 5'd1, 5'd0, 5'd9);
    tick();
    drive(CTL_SD, 5'd1, 5'd9, 5'd0);
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_no_stall: stall=%b required 0", stall_o);
    end
    tick();
    n_checks++;
    if (control_o !== CTL_SD || bubble_cnt_o !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL addi_store_direct: ctl=%h cnt=%0d required %h %0d", control_o, bubble_cnt_o, CTL_SD, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    drive(CTL_LD, 5'd1, 5'd0, 5'd5);
    tick();
    drive(CTL_LD, 5'd5, 5'd0, 5'd6);
    n_checks++;
    if (stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_stall: stall=%b required 1", stall_o);
    end
    tick();
    exp_cnt++;
    n_checks++;
    if (control_o !== 8'h00 || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first_bubble: ctl=%h stall=%b required 00 0", control_o, stall_o);
    end
    tick();
    drive(CTL_R, 5'd6, 5'd2, 5'd10);
    n_checks++;
    if (control_o !== CTL_LD || rd_addr_o !== 5'd6 || stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_load: ctl=%h rd=%0d stall=%b required %h 6 1",
               control_o, rd_addr_o, stall_o, CTL_LD);
    end
    tick();
    exp_cnt++;
    n_checks++;
    if (control_o !== 8'h00 || bubble_cnt_o !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL b2b_second_bubble: ctl=%h cnt=%0d required 00 %0d", control_o, bubble_cnt_o, exp_cnt);
    end
    tick();
    n_checks++;
    if (control_o !== CTL_R || rd_addr_o !== 5'd10) begin
      n_fail++;
      $display("FAIL b2b_consumer: ctl=%h rd=%0d required %h 10", control_o, rd_addr_o, CTL_R);
    end
  endtask

  task automatic test_saturation();
    int exp_sat;
    #2 rst_i = 1'b0;
    drive(CTL_R, 5'd1, 5'd2, 5'd3);
    @(negedge clk);
    rst_i = 1'b1;
    exp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      drive(CTL_LD, 5'd1, 5'd0, 5'd20);
      tick();
      drive(CTL_R, 5'd2, 5'd20, 5'd21);
      tick();
      exp_cnt++;
      exp_sat = (exp_cnt > 3) ? 3 : exp_cnt;
      n_checks++;
      if (s_control_o !== 8'h00 || s_rd_addr_o !== 5'd0 || control_o !== 8'h00) begin
        n_fail++;
        $display("FAIL sat_bubble_%0d: sat_ctl=%h sat_rd=%0d ctl=%h required 00 0 00",
                 k, s_control_o, s_rd_addr_o, control_o);
      end
      n_checks++;
      if (s_bubble_cnt_o !== 2'(exp_sat) || bubble_cnt_o !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL sat_count_%0d: sat_cnt=%0d cnt=%0d required %0d %0d",
                 k, s_bubble_cnt_o, bubble_cnt_o, exp_sat, exp_cnt);
      end
      tick();
    end
  endtask

  initial begin
    rst_i = 1'b0;
    control_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; funct_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_passthrough();
    test_load_use();
    test_no_false_hazard();
    test_rs2_and_non_load();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the 5-stage RISC-V core. It sits directly downstream of the decode control unit and latches the 8-bit control word, register operands, immediate and register addresses for the EX stage. It also contains load-use hazard detection: on a hazard it asserts a stall towards PC and IF/ID and injects a bubble into EX. A saturating counter records how many bubbles were inserted, for performance debug.

## Interface
- DATA_W, 32, operand and immediate width
- CNT_W, 16, bubble counter width
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- control_i  in  8  decode control word {ALUOp[1:0], ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Branch} (bit 7 down to bit 0)
- rs1_data_i, rs2_data_i  in  DATA_W  register file read data
- imm_i  in  DATA_W  sign-extended immediate
- funct_i  in  10  {funct7, funct3}
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5  ID-stage register addresses
- control_o  out  8  EX-stage control word
- rs1_data_o, rs2_data_o, imm_o  out  DATA_W  EX-stage operands
- funct_o  out  10  EX-stage funct
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  5  EX-stage addresses, used by forwarding
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_cnt_o  out  CNT_W  number of bubbles inserted since reset, saturating

## Operation
- Hazard condition: control_o MemRead (bit 2) = 1, rd_addr_o != 0, and (rd_addr_o == rs1_addr_i or rd_addr_o == rs2_addr_i).
- Both source addresses are compared for every opcode. Over-stalling on I-type instructions is accepted.
- stall_o = hazard condition. It is purely combinational and is never registered.
- Normal edge (no hazard): every output register loads its corresponding input.
- Hazard edge:
  - control_o and rd_addr_o load 0, which is the bubble.
  - All data, funct and source-address registers still load their inputs; their values are don't-care under a bubble.
- Only a zeroed control word is a bubble. An all-zero opcode that arrives through control_i is treated as a normal load, not counted.
- Load-use sequence: after one bubble, control_o MemRead = 0, so stall_o drops. Each load-use therefore costs exactly one stall cycle.
- Back-to-back load-use on a dependent load works as expected: the second load follows the first by one bubble and then stalls its own consumer.
- bubble_cnt_o increments by 1 on each hazard edge and saturates at 2^CNT_W-1 (no wrap).
- Branch resolution happens upstream. This block has no flush input.

## Timing
- Latency: 1 cycle, ID inputs to EX outputs.
- stall_o is valid in the same cycle as the ID inputs. The path runs from EX registers through a comparator to stall_o.
- Reset (rst_i = 0, any time, asynchronous): all outputs are 0 immediately, including control_o (a bubble), rd_addr_o, all data registers and bubble_cnt_o. stall_o is therefore 0 during reset.
- Reset deasserted mid-stream: the first edge after release loads normally. No stall can occur on that edge because EX holds a bubble.
- Hazard together with counter saturation: the bubble is still inserted and the counter holds its maximum value.

## Structure
- Shared package `cpu_pkg`:
  - control-word bit indices: CTL_BRANCH = 0, CTL_MEMWRITE = 1, CTL_MEMREAD = 2, CTL_MEMTOREG = 3, CTL_REGWRITE = 4, CTL_ALUSRC = 5, CTL_ALUOP = 7:6
  - CTL_W = 8, REG_ADDR_W = 5
  - opcode constants (R-type, I-type, load, store, branch)
- One sub-module, `load_use_detect`. It is purely combinational: it takes the EX MemRead bit, the EX rd and the ID rs1/rs2 and outputs hazard. It is instantiated once; the register bank lives in id_ex_stage.

## Test plan
- Reset: drive all inputs non-zero, pulse rst_i low mid-cycle -> every output reads 0 immediately, stall_o = 0.
- Pass-through: control_i = 8'b10010000 (R-type), rs1_data_i = 5, rs2_data_i = 7, rd_addr_i = 3 -> next edge control_o = 8'b10010000, rs1_data_o = 5, rd_addr_o = 3, stall_o never asserted.
- Load-use:
  - stimulus: ld with rd = 5 (control 8'b00111100) followed by add with rs1 = 5
  - response: stall_o = 1 for exactly one cycle, next control_o = 0 and rd_addr_o = 0, bubble_cnt_o = 1, add enters EX on the following edge.
- No false hazard:
  - ld with rd = 0 followed by a consumer of x0 -> stall_o = 0.
  - ld rd = 5 followed by a consumer of rs1 = 6, rs2 = 7 -> stall_o = 0.
- rs2 match and non-load producer: ld rd = 9 followed by sd with rs2 = 9 -> one stall. Addi rd = 9 followed by the same sd -> no stall.
- Saturation: with CNT_W = 2, force 5 load-use pairs -> bubble_cnt_o sticks at 3, and every pair still gets its bubble.
